// File: rtl/spatz_xmem_responder.sv
// Memory-side responder for one Spatz VLSU X-interface port: synchronous
// exception response, TCDM request forwarding and an in-order result buffer.
module spatz_xmem_responder #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   xmem_valid_i,
  output logic                   xmem_ready_o,
  input  logic [AddrWidth-1:0]   xmem_addr_i,
  input  logic                   xmem_we_i,
  input  logic [1:0]             xmem_size_i,
  input  logic [DataWidth-1:0]   xmem_wdata_i,
  input  logic [IdWidth-1:0]     xmem_id_i,
  output logic                   xmem_exc_o,
  output logic [5:0]             xmem_exccode_o,
  output logic                   xmem_result_valid_o,
  output logic [DataWidth-1:0]   xmem_result_rdata_o,
  output logic [IdWidth-1:0]     xmem_result_id_o,
  output logic                   xmem_result_err_o,
  input  logic                   xmem_finished_i,
  output logic                   done_o,
  output logic                   idle_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);
  localparam int unsigned BW   = DataWidth / 8;
  localparam int unsigned OFFW = $clog2(BW);
  localparam int unsigned PW   = $clog2(MaxOutstanding);
  localparam int unsigned CW   = PW + 1;

  function automatic logic [BW-1:0] lane_mask(input logic [3:0] nbytes, input logic [OFFW-1:0] off);
    logic [BW-1:0] m;
    for (int j = 0; j < BW; j++) m[j] = (j >= int'(off)) && (j < int'(off) + int'(nbytes));
    return m;
  endfunction

  function automatic logic [DataWidth-1:0] size_mask(input logic [1:0] size);
    logic [DataWidth-1:0] m;
    for (int b = 0; b < DataWidth; b++) m[b] = (b < (8 << size));
    return m;
  endfunction

  logic [PW-1:0]             head_q, tail_q, mptr;
  logic [CW-1:0]             count_q;
  logic [MaxOutstanding-1:0] err_q, done_q, we_q;
  logic [IdWidth-1:0]        id_q   [MaxOutstanding];
  logic [OFFW-1:0]           off_q  [MaxOutstanding];
  logic [1:0]                size_q [MaxOutstanding];
  logic [DataWidth-1:0]      data_q [MaxOutstanding];
  logic                      ign_q, finished_q;

  logic [3:0]           nbytes;
  logic [2:0]           lo;
  logic [OFFW-1:0]      off;
  logic                 misaligned, full, hs, grant, mfound, rv_ok;
  logic [DataWidth-1:0] rv_data;
  logic                 pop, pop_err, done_cond;
  logic [DataWidth-1:0] pop_data;
  logic [IdWidth-1:0]   pop_id;

  assign nbytes     = 4'd1 << xmem_size_i;
  assign lo         = xmem_addr_i[2:0];
  assign off        = xmem_addr_i[OFFW-1:0];
  assign misaligned = ((lo & (nbytes[2:0] - 3'd1)) != 3'd0) || (32'(nbytes) > BW);
  assign full       = (count_q == CW'(MaxOutstanding));

  assign mem_req_o      = xmem_valid_i && !misaligned && !full;
  assign xmem_ready_o   = !full && (misaligned || mem_gnt_i);
  assign hs             = xmem_valid_i && xmem_ready_o;
  assign grant          = mem_req_o && mem_gnt_i;
  assign xmem_exc_o     = xmem_valid_i && misaligned;
  assign xmem_exccode_o = xmem_exc_o ? (xmem_we_i ? 6'd6 : 6'd4) : 6'd0;
  assign idle_o         = (count_q == '0);

  // Memory-side fields are held at zero whenever no request is presented.
  assign mem_addr_o  = mem_req_o ? {xmem_addr_i[AddrWidth-1:OFFW], {OFFW{1'b0}}} : '0;
  assign mem_we_o    = mem_req_o && xmem_we_i;
  assign mem_be_o    = mem_req_o ? lane_mask(nbytes, off) : '0;
  assign mem_wdata_o = mem_req_o ? (xmem_wdata_i << {off, 3'b000}) : '0;

  // Oldest entry still waiting on memory; excepted entries never get a response.
  always_comb begin
    mptr   = head_q;
    mfound = 1'b0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (!mfound && (CW'(i) < count_q) && !err_q[head_q + PW'(i)] && !done_q[head_q + PW'(i)]) begin
        mptr   = head_q + PW'(i);
        mfound = 1'b1;
      end
    end
  end

  assign rv_ok   = mem_rvalid_i && !ign_q && mfound;
  assign rv_data = we_q[mptr] ? '0 : ((mem_rdata_i >> {off_q[mptr], 3'b000}) & size_mask(size_q[mptr]));

  // Pop sees completions arriving this cycle so results leave one cycle after rvalid.
  always_comb begin
    if (count_q == '0) begin
      pop      = hs && misaligned;
      pop_data = '0;
      pop_id   = xmem_id_i;
      pop_err  = 1'b1;
    end else begin
      pop      = done_q[head_q] || (rv_ok && (mptr == head_q));
      pop_data = done_q[head_q] ? data_q[head_q] : rv_data;
      pop_id   = id_q[head_q];
      pop_err  = err_q[head_q];
    end
  end

  assign done_cond = (finished_q || xmem_finished_i) && (count_q == '0) && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      err_q               <= '0;
      done_q              <= '0;
      ign_q               <= 1'b1;
      finished_q          <= 1'b0;
      done_o              <= 1'b0;
      xmem_result_valid_o <= 1'b0;
      xmem_result_rdata_o <= '0;
      xmem_result_id_o    <= '0;
      xmem_result_err_o   <= 1'b0;
    end else begin
      if (hs) begin
        err_q[tail_q]  <= misaligned;
        done_q[tail_q] <= misaligned;
        tail_q         <= tail_q + 1'b1;
      end
      if (rv_ok) done_q[mptr] <= 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(hs) - CW'(pop);
      if (grant) ign_q <= 1'b0;
      // Result stage boundary
      xmem_result_valid_o <= pop;
      if (pop) begin
        xmem_result_rdata_o <= pop_data;
        xmem_result_id_o    <= pop_id;
        xmem_result_err_o   <= pop_err;
      end
      finished_q <= (finished_q || xmem_finished_i) && !done_cond;
      done_o     <= done_cond;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) begin
      id_q[tail_q]   <= xmem_id_i;
      we_q[tail_q]   <= xmem_we_i;
      off_q[tail_q]  <= off;
      size_q[tail_q] <= xmem_size_i;
      data_q[tail_q] <= '0;
    end
    if (rv_ok) data_q[mptr] <= rv_data;
  end
endmodule

// File: tb/tb_spatz_xmem_responder.sv
// Scoreboard bench for spatz_xmem_responder: byte-level memory model,
// randomized TCDM grant/latency, in-order result checking.
module tb_spatz_xmem_responder;
  localparam int AW = 32, DW = 64, IW = 4, MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, xmem_valid_i, xmem_ready_o, xmem_we_i, xmem_exc_o;
  logic [AW-1:0] xmem_addr_i, mem_addr_o;
  logic [1:0]    xmem_size_i;
  logic [DW-1:0] xmem_wdata_i, xmem_result_rdata_o, mem_wdata_o, mem_rdata_i;
  logic [IW-1:0] xmem_id_i, xmem_result_id_o;
  logic [5:0]    xmem_exccode_o;
  logic          xmem_result_valid_o, xmem_result_err_o, xmem_finished_i, done_o, idle_o;
  logic          mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic [7:0]    mem_be_o;

  spatz_xmem_responder #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .xmem_valid_i(xmem_valid_i), .xmem_ready_o(xmem_ready_o), .xmem_addr_i(xmem_addr_i),
    .xmem_we_i(xmem_we_i), .xmem_size_i(xmem_size_i), .xmem_wdata_i(xmem_wdata_i),
    .xmem_id_i(xmem_id_i), .xmem_exc_o(xmem_exc_o), .xmem_exccode_o(xmem_exccode_o),
    .xmem_result_valid_o(xmem_result_valid_o), .xmem_result_rdata_o(xmem_result_rdata_o),
    .xmem_result_id_o(xmem_result_id_o), .xmem_result_err_o(xmem_result_err_o),
    .xmem_finished_i(xmem_finished_i), .done_o(done_o), .idle_o(idle_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  typedef struct { logic [IW-1:0] id; logic err; logic [63:0] data; } res_t;
  typedef struct { int due; logic [31:0] wa; } pend_t;

  res_t  sb_q[$];
  pend_t pend_q[$];
  int    n_checks = 0, n_pass = 0;
  int    cyc = 0;
  int    gnt_mode = 0;   // 0: no grant, 1: always grant, 2: random grant
  int    lat_fixed = 0;  // 0: random latency 1..4
  bit    hold_rv = 1'b0;
  int    last_grant_cyc = 0, last_res_cyc = 0, prev_res_cyc = 0, res_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] wa);
    if (wa == 32'h1000) return 64'h1122334455667788;
    if (wa == 32'h2000) return 64'hDEADBEEF_CAFEF00D;
    return {wa * 32'h9E3779B1, ~wa ^ 32'h5A5A1234};
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [63:0] w;
    w = mem_word({a[31:3], 3'b000});
    return w[8*a[2:0] +: 8];
  endfunction

  function automatic bit is_mis(input logic [31:0] addr, input logic [1:0] size);
    return ((addr % (32'd1 << size)) != 0) || ((1 << size) > DW / 8);
  endfunction

  function automatic res_t expect_res(input logic [31:0] addr, input logic we,
                                      input logic [1:0] size, input logic [IW-1:0] id);
    res_t r;
    r.id = id; r.err = is_mis(addr, size); r.data = '0;
    if (!r.err && !we)
      for (int k = 0; k < (1 << size); k++) r.data[8*k +: 8] = mem_byte(addr + k);
    return r;
  endfunction

  // Grant driver
  always @(posedge clk) begin
    #1;
    mem_gnt_i = (gnt_mode == 1) || ((gnt_mode == 2) && ($urandom_range(0, 9) < 7));
  end

  // Memory: record grants, check lane mapping, answer in order after the latency
  int          g_off, g_n, g_lat;
  logic [7:0]  g_be;
  logic [63:0] g_wexp, g_wmask;
  always @(negedge clk) begin
    if (!rst && mem_req_o && mem_gnt_i) begin
      g_lat = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
      pend_q.push_back('{cyc + g_lat, mem_addr_o});
      last_grant_cyc = cyc;
      g_off = xmem_addr_i % 8; g_n = 1 << xmem_size_i;
      g_be = '0; g_wexp = '0; g_wmask = '0;
      for (int j = 0; j < 8; j++)
        if (j >= g_off && j < g_off + g_n) begin
          g_be[j] = 1'b1;
          g_wmask[8*j +: 8] = 8'hFF;
          g_wexp[8*j +: 8] = xmem_wdata_i[8*(j-g_off) +: 8];
        end
      check("mem_addr", mem_addr_o, {xmem_addr_i[31:3], 3'b000});
      check("mem_be", mem_be_o, g_be);
      check("mem_we", mem_we_o, xmem_we_i);
      if (xmem_we_i) check("mem_wdata", mem_wdata_o & g_wmask, g_wexp);
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = {$urandom, $urandom};
    if (!hold_rv && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(pend_q[0].wa);
      void'(pend_q.pop_front());
    end
  end

  // Result monitor
  res_t mon_e;
  always @(negedge clk) begin
    if (xmem_result_valid_o) begin
      prev_res_cyc = last_res_cyc; last_res_cyc = cyc; res_cnt++;
      if (sb_q.size() == 0) check("unexpected_result", xmem_result_valid_o, 1'b0);
      else begin
        mon_e = sb_q.pop_front();
        check("result{id,err,data}", {xmem_result_id_o, xmem_result_err_o, xmem_result_rdata_o},
              {mon_e.id, mon_e.err, mon_e.data});
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic [63:0] wdata, input logic [IW-1:0] id);
    res_t e;
    int   n;
    e = expect_res(addr, we, size, id);
    n = 0;
    xmem_valid_i = 1'b1; xmem_addr_i = addr; xmem_we_i = we;
    xmem_size_i = size; xmem_wdata_i = wdata; xmem_id_i = id;
    forever begin
      @(negedge clk);
      if (xmem_ready_o) begin
        check("exc", xmem_exc_o, e.err);
        check("exccode", xmem_exccode_o, e.err ? (we ? 6'd6 : 6'd4) : 6'd0);
        check("mem_req_at_hs", mem_req_o, !e.err);
        sb_q.push_back(e);
        break;
      end
      n++;
      if (n >= 300) begin
        check("issue_timeout", xmem_ready_o, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    xmem_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || pend_q.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    check(name, n < 300, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic finish_pulse(input string name);
    xmem_finished_i = 1'b1;
    @(negedge clk); check({name, "_same_cycle"}, done_o, 1'b0);
    @(posedge clk); #1; xmem_finished_i = 1'b0;
    @(negedge clk); check({name, "_pulse"}, done_o, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); check({name, "_cleared"}, done_o, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int res_before;
  initial begin
    rst = 1'b1; xmem_valid_i = 1'b0; xmem_addr_i = '0; xmem_we_i = 1'b0; xmem_size_i = '0;
    xmem_wdata_i = '0; xmem_id_i = '0; xmem_finished_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result_valid", xmem_result_valid_o, 1'b0);
    check("reset_idle", idle_o, 1'b1);
    check("reset_done", done_o, 1'b0);
    check("reset_ready", xmem_ready_o, 1'b0);
    check("reset_mem_req", mem_req_o, 1'b0);
    @(posedge clk); #1; rst = 1'b0;

    // Aligned dword load, fixed latency 2
    gnt_mode = 1; lat_fixed = 2;
    issue(32'h1000, 1'b0, 2'd3, 64'h0, 4'd3);
    wait_drain("drain_dword_load");
    check("load_latency", last_res_cyc - last_grant_cyc, 3);

    // Byte store into lane 5
    issue(32'h1005, 1'b1, 2'd0, 64'hAB, 4'd2);
    wait_drain("drain_byte_store");

    // Misaligned load behind an outstanding load
    hold_rv = 1'b1;
    issue(32'h1008, 1'b0, 2'd3, 64'h0, 4'd6);
    issue(32'h1003, 1'b0, 2'd1, 64'h0, 4'd7);
    hold_rv = 1'b0;
    wait_drain("drain_misaligned");
    check("exc_result_next_cycle", last_res_cyc - prev_res_cyc, 1);

    // Fill the buffer with rvalid withheld
    hold_rv = 1'b1;
    for (int i = 0; i < 4; i++) issue(32'h1100 + 8 * i, 1'b0, 2'd3, 64'h0, IW'(8 + i));
    xmem_valid_i = 1'b1; xmem_addr_i = 32'h1120; xmem_we_i = 1'b0; xmem_size_i = 2'd3; xmem_id_i = 4'd12;
    @(negedge clk); check("full_ready", xmem_ready_o, 1'b0);
    check("full_no_req", mem_req_o, 1'b0);
    hold_rv = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); check("full_pop_cycle_ready", xmem_ready_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); check("ready_after_pop", xmem_ready_o, 1'b1);
    if (xmem_ready_o) sb_q.push_back(expect_res(32'h1120, 1'b0, 2'd3, 4'd12));
    @(posedge clk); #1; xmem_valid_i = 1'b0;
    wait_drain("drain_full");

    // Word load from the upper lane
    issue(32'h2004, 1'b0, 2'd2, 64'h0, 4'd5);
    wait_drain("drain_word_load");

    // Reset with three loads outstanding, then stale responses
    hold_rv = 1'b1;
    for (int i = 0; i < 3; i++) issue(32'h1200 + 8 * i, 1'b0, 2'd3, 64'h0, IW'(i));
    check("stale_setup", pend_q.size(), 3);
    rst = 1'b1; sb_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    while (pend_q.size() > 2) void'(pend_q.pop_back());
    hold_rv = 1'b0;
    res_before = res_cnt;
    repeat (6) @(negedge clk);
    check("stale_results", res_cnt - res_before, 0);
    check("idle_after_reset", idle_o, 1'b1);
    @(posedge clk); #1;
    finish_pulse("done_empty");

    // Randomized traffic
    gnt_mode = 2; lat_fixed = 0;
    for (int i = 0; i < 150; i++) begin
      issue(32'h1000 + $urandom_range(0, 4095), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, IW'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain("drain_random");
    repeat (2) begin @(posedge clk); #1; end
    finish_pulse("done_after_random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spatz_xmem_responder.md
Name: spatz_xmem_responder

Overview:
- Memory-side end of the X-interface memory channel. Accepts scalar-width memory requests from one Spatz VLSU memory port.
- Returns the synchronous exception response in the same cycle as each request, forwards aligned requests to a TCDM-style req/gnt/rvalid port, and returns results strictly in request order.
- Instantiated once per memory port between the Spatz top level and the cluster interconnect.

Parameters:
- AddrWidth, 32, request/memory address width.
- DataWidth, 64, data width. Must be 32 or 64.
- IdWidth, 4, width of the request ID echoed on the result.
- MaxOutstanding, 4, depth of the in-order result buffer. Must be a power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- xmem_valid_i  in  1  request valid
- xmem_ready_o  out  1  request ready
- xmem_addr_i  in  AddrWidth  byte address
- xmem_we_i  in  1  1 = store, 0 = load
- xmem_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword
- xmem_wdata_i  in  DataWidth  store data, LSB-aligned
- xmem_id_i  in  IdWidth  request ID
- xmem_exc_o  out  1  exception response, valid during handshake
- xmem_exccode_o  out  6  exception code, valid during handshake
- xmem_result_valid_o  out  1  result valid; no backpressure
- xmem_result_rdata_o  out  DataWidth  load data, LSB-aligned, zero-extended
- xmem_result_id_o  out  IdWidth  echoed ID
- xmem_result_err_o  out  1  result belongs to an excepted request
- xmem_finished_i  in  1  one-cycle pulse: VLSU issued its last request
- done_o  out  1  one-cycle pulse: finished seen and buffer drained
- idle_o  out  1  buffer empty
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_addr_o  out  AddrWidth  word-aligned address
- mem_we_o  out  1  write enable
- mem_be_o  out  DataWidth/8  byte enables
- mem_wdata_o  out  DataWidth  lane-shifted write data
- mem_rvalid_i  in  1  memory response; one per grant, in order, at least 1 cycle after grant
- mem_rdata_i  in  DataWidth  memory read data

Behaviour:
- Reset (rst_i high at a clock edge) clears the buffer, all pointers and the finished flag. All outputs except idle_o reset to 0; idle_o resets to 1. A reset mid-operation drops all outstanding entries. mem_rvalid_i pulses for dropped requests are ignored until the first new grant after reset.
- Misaligned: addr mod 2^size != 0, or 2^size > DataWidth/8.
- Handshake combinational paths:
  - full = (count == MaxOutstanding).
  - mem_req_o = xmem_valid_i & !misaligned & !full.
  - xmem_ready_o = !full & (misaligned | mem_gnt_i).
  - xmem_exc_o = xmem_valid_i & misaligned.
  - xmem_exccode_o = 6 for a misaligned store, 4 for a misaligned load, otherwise 0.
- Lane mapping: off = addr mod (DataWidth/8).
  - mem_addr_o = addr with the low log2(DataWidth/8) bits cleared.
  - mem_be_o = ((1 << 2^size) - 1) << off.
  - mem_wdata_o = wdata << (8*off).
- Buffer entry: {id, err, we, off, size, done, data}. Entries are allocated in order on each handshake.
  - Misaligned entries are allocated with err=1, done=1 and are never sent to memory.
- Memory pointer: tracks the oldest entry with err=0 and done=0.
  - On mem_rvalid_i, that entry takes data = (rdata >> 8*off), masked to 2^size bytes; stores take data 0. The entry sets done=1.
- Pop: the head entry pops when done=1. At most one pop per cycle.
- Result registers: on a pop, next cycle xmem_result_valid_o = 1 with the entry's data, id and err.
  - Latency: load granted at t, rvalid at t+L, result at t+L+1.
  - Excepted request accepted at t while at the head: result at t+1.
- Simultaneous events: allocate, rvalid write and pop in the same cycle are all legal. count is unchanged when allocate and pop coincide.
  - Full and a pop in the same cycle: ready remains 0 that cycle, because ready is based on the registered count.
- Pointers wrap modulo MaxOutstanding. count has width log2(MaxOutstanding)+1.
- Stores also produce a result (data 0) so the VLSU can count completions.
- Finished handling:
  - finished_q is set by xmem_finished_i.
  - done_o = (finished_q | xmem_finished_i) & (count == 0) & no pop this cycle & result register empty next cycle. done_o pulses for one cycle and clears finished_q.
  - If xmem_finished_i arrives while the buffer is already empty, done_o pulses in the next cycle.
- idle_o = (count == 0).

Test Plan:
- Aligned dword load, addr 0x1000, id 3, memory latency 2 cycles, rdata 0x1122334455667788 → mem_be_o 0xFF; xmem_result_valid_o 3 cycles after grant; rdata 0x1122334455667788, id 3, err 0.
- Byte store, addr 0x1005, wdata 0xAB, size 0 → mem_addr_o 0x1000, mem_be_o 0x20, mem_wdata_o bits [47:40] = 0xAB; result with rdata 0, err 0.
- Misaligned half load at 0x1003, id 7, issued behind an outstanding load with id 6 → exc 1 and exccode 4 during handshake; no mem_req_o; results in order: id 6 (err 0), then id 7 (err 1, next cycle).
- mem_gnt_i held 1, rvalid withheld, 5 back-to-back loads → xmem_ready_o drops after 4 accepts; rises the cycle after the first result pops; 5 results in ID order.
- Word load at 0x2004, rdata 0xDEADBEEF_CAFEF00D → result rdata 0x00000000DEADBEEF.
- Assert rst_i with 3 requests outstanding, then apply 2 stale rvalid pulses → no results; idle_o = 1; xmem_finished_i afterwards → done_o pulses exactly one cycle later.
